reorder_buffer: RTL and testbench

- Circular reorder buffer that the issue stage allocates into at the tail; entries retire in program order from the head.
- Exports head, tail and empty back to the issue stage. Because it also exports an empty flag, head==tail means full when the buffer is not empty.
- Collects results from the common data bus (CDB) and commits one entry per cycle to the register file or the load/store buffer.
- Flushes the pipeline when a mispredicted branch reaches the head.

---
 rtl/reorder_buffer_pkg.sv | 13 +
 rtl/reorder_buffer_rob_ptr_ctrl.sv | 57 +++++
 rtl/reorder_buffer.sv | 148 ++++++++++++++
 tb/tb_reorder_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing and constants for the reorder buffer slice.
package reorder_buffer_pkg;

  localparam int ROBIdxWidth = 4;
  localparam int ROBSize     = 1 << ROBIdxWidth;
  localparam int RegIdxWidth = 5;
  localparam int DataWidth   = 32;

  localparam logic        TRUE  = 1'b1;
  localparam logic        FALSE = 1'b0;
  localparam logic [31:0] ZERO  = '0;

endpackage

// File: rtl/reorder_buffer_rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer; flush returns everything to slot 0.
module rob_ptr_ctrl
  import reorder_buffer_pkg::*;
#(
  parameter int W = ROBIdxWidth
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  input  logic         alloc,
  input  logic         commit,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [W-1:0] tail,
  output logic         empty,
  output logic         full
);

  logic [W:0] count_q;
  logic [W:0] count_next;
  logic       empty_q;

  // Count can reach exactly 2^W, so its MSB alone marks the full state.
  assign full  = count_q[W];
  assign empty = empty_q;

  always_comb begin
    count_next = count_q;
    case ({alloc, commit})
      2'b10:   count_next = count_q + (W+1)'(1);
      2'b01:   count_next = count_q - (W+1)'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      empty_q <= TRUE;
    end else if (rdy) begin
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
        empty_q <= TRUE;
      end else begin
        if (commit) head <= head + W'(1);
        if (alloc)  tail <= tail + W'(1);
        count_q <= count_next;
        empty_q <= (count_next == '0);
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with CDB writeback and head-of-buffer mispredict flush.
// Define ROB_PERF_CNT_EN to add commit/flush performance counters.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_IDX_WIDTH = ROBIdxWidth,
  parameter int REG_IDX_WIDTH = RegIdxWidth,
  parameter int DATA_WIDTH    = DataWidth
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     issue_en_in,
  input  logic [REG_IDX_WIDTH-1:0] issue_rd_in,
  input  logic                     issue_is_store_in,
  input  logic                     issue_is_branch_in,
  output logic                     rob_empty_out,
  output logic [ROB_IDX_WIDTH-1:0] rob_head_out,
  output logic [ROB_IDX_WIDTH-1:0] rob_tail_out,
  input  logic                     cdb_en_in,
  input  logic [ROB_IDX_WIDTH-1:0] cdb_idx_in,
  input  logic [DATA_WIDTH-1:0]    cdb_value_in,
  input  logic                     cdb_mispredict_in,
  input  logic [DATA_WIDTH-1:0]    cdb_target_in,
  output logic                     commit_reg_en_out,
  output logic [REG_IDX_WIDTH-1:0] commit_rd_out,
  output logic [DATA_WIDTH-1:0]    commit_value_out,
  output logic [ROB_IDX_WIDTH-1:0] commit_idx_out,
  output logic                     commit_store_en_out,
  output logic                     flush_out,
  output logic [DATA_WIDTH-1:0]    flush_pc_out
`ifdef ROB_PERF_CNT_EN
 ,output logic [31:0]              commit_cnt_out,
  output logic [31:0]              flush_cnt_out
`endif
);

  localparam int Entries = 1 << ROB_IDX_WIDTH;

  logic [Entries-1:0]       busy_q, ready_q, mispredict_q, is_store_q, is_branch_q;
  logic [REG_IDX_WIDTH-1:0] rd_q     [Entries];
  logic [DATA_WIDTH-1:0]    value_q  [Entries];
  logic [DATA_WIDTH-1:0]    target_q [Entries];

  logic [ROB_IDX_WIDTH-1:0] head, tail;
  logic full, commit_fire, flush, alloc_ok, cdb_ok;

  assign commit_fire = busy_q[head] & ready_q[head];
  assign flush       = commit_fire & mispredict_q[head] & is_branch_q[head];
  // A full buffer still accepts an allocation when the head retires in the same edge.
  assign alloc_ok    = issue_en_in & (~full | commit_fire) & ~flush;
  assign cdb_ok      = cdb_en_in & busy_q[cdb_idx_in] & ~flush;

  rob_ptr_ctrl #(.W(ROB_IDX_WIDTH)) u_ptr (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .rdy    (rdy_in),
    .alloc  (alloc_ok),
    .commit (commit_fire),
    .flush  (flush),
    .head   (head),
    .tail   (tail),
    .empty  (rob_empty_out),
    .full   (full)
  );

  assign rob_head_out = head;
  assign rob_tail_out = tail;

  // Allocation is applied last so it wins over the retiring head when tail==head.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q       <= '0;
      ready_q      <= '0;
      mispredict_q <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        busy_q       <= '0;
        ready_q      <= '0;
        mispredict_q <= '0;
      end else begin
        if (cdb_ok) begin
          ready_q[cdb_idx_in]      <= TRUE;
          mispredict_q[cdb_idx_in] <= cdb_mispredict_in;
        end
        if (commit_fire) busy_q[head] <= FALSE;
        if (alloc_ok) begin
          busy_q[tail]       <= TRUE;
          ready_q[tail]      <= issue_is_store_in;
          mispredict_q[tail] <= FALSE;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (cdb_ok) begin
        value_q[cdb_idx_in]  <= cdb_value_in;
        target_q[cdb_idx_in] <= cdb_target_in;
      end
      if (alloc_ok) begin
        rd_q[tail]        <= issue_rd_in;
        is_store_q[tail]  <= issue_is_store_in;
        is_branch_q[tail] <= issue_is_branch_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_reg_en_out   <= FALSE;
      commit_store_en_out <= FALSE;
      flush_out           <= FALSE;
      commit_rd_out       <= '0;
      commit_value_out    <= '0;
      commit_idx_out      <= '0;
      flush_pc_out        <= '0;
    end else if (!rdy_in) begin
      commit_reg_en_out   <= FALSE;
      commit_store_en_out <= FALSE;
      flush_out           <= FALSE;
    end else begin
      commit_reg_en_out   <= commit_fire & ~is_store_q[head] & (rd_q[head] != '0);
      commit_store_en_out <= commit_fire & is_store_q[head];
      flush_out           <= flush;
      if (commit_fire) begin
        commit_rd_out    <= rd_q[head];
        commit_value_out <= value_q[head];
        commit_idx_out   <= head;
      end
      if (flush) flush_pc_out <= target_q[head];
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_cnt_out <= ZERO;
      flush_cnt_out  <= ZERO;
    end else if (rdy_in) begin
      if (commit_fire) commit_cnt_out <= commit_cnt_out + 32'd1;
      if (flush)       flush_cnt_out  <= flush_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, CDB commit, full wrap, flush, stores and stall.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        issue_en_in;
  logic [4:0]  issue_rd_in;
  logic        issue_is_store_in;
  logic        issue_is_branch_in;
  logic        rob_empty_out;
  logic [3:0]  rob_head_out;
  logic [3:0]  rob_tail_out;
  logic        cdb_en_in;
  logic [3:0]  cdb_idx_in;
  logic [31:0] cdb_value_in;
  logic        cdb_mispredict_in;
  logic [31:0] cdb_target_in;
  logic        commit_reg_en_out;
  logic [4:0]  commit_rd_out;
  logic [31:0] commit_value_out;
  logic [3:0]  commit_idx_out;
  logic        commit_store_en_out;
  logic        flush_out;
  logic [31:0] flush_pc_out;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] commit_cnt_out;
  logic [31:0] flush_cnt_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .rdy_in              (rdy_in),
    .issue_en_in         (issue_en_in),
    .issue_rd_in         (issue_rd_in),
    .issue_is_store_in   (issue_is_store_in),
    .issue_is_branch_in  (issue_is_branch_in),
    .rob_empty_out       (rob_empty_out),
    .rob_head_out        (rob_head_out),
    .rob_tail_out        (rob_tail_out),
    .cdb_en_in           (cdb_en_in),
    .cdb_idx_in          (cdb_idx_in),
    .cdb_value_in        (cdb_value_in),
    .cdb_mispredict_in   (cdb_mispredict_in),
    .cdb_target_in       (cdb_target_in),
    .commit_reg_en_out   (commit_reg_en_out),
    .commit_rd_out       (commit_rd_out),
    .commit_value_out    (commit_value_out),
    .commit_idx_out      (commit_idx_out),
    .commit_store_en_out (commit_store_en_out),
    .flush_out           (flush_out),
    .flush_pc_out        (flush_pc_out)
`ifdef ROB_PERF_CNT_EN
   ,.commit_cnt_out      (commit_cnt_out),
    .flush_cnt_out       (flush_cnt_out)
`endif
  );

  // Inputs change on the falling edge; one step = rising edge, then sample on the next falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle();
    issue_en_in = 0; issue_rd_in = '0; issue_is_store_in = 0; issue_is_branch_in = 0;
    cdb_en_in = 0; cdb_idx_in = '0; cdb_value_in = '0; cdb_mispredict_in = 0; cdb_target_in = '0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic st, input logic br);
    issue_en_in = 1; issue_rd_in = rd; issue_is_store_in = st; issue_is_branch_in = br;
  endtask

  task automatic cdb(input logic [3:0] idx, input logic [31:0] val, input logic mp, input logic [31:0] tgt);
    cdb_en_in = 1; cdb_idx_in = idx; cdb_value_in = val; cdb_mispredict_in = mp; cdb_target_in = tgt;
  endtask

  task automatic do_reset();
    idle();
    rdy_in = 1;
    rst_n_in = 0;
    @(negedge clk_in);
    rst_n_in = 1;
  endtask

  task automatic test_reset();
    idle();
    rdy_in = 1;
    rst_n_in = 0;
    @(negedge clk_in);
    total++; if (rob_empty_out !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%0b exp=1", rob_empty_out); end
    total++; if (rob_head_out !== 4'd0) begin bad++; $display("[TB] FAIL reset_head got=%0d exp=0", rob_head_out); end
    total++; if (rob_tail_out !== 4'd0) begin bad++; $display("[TB] FAIL reset_tail got=%0d exp=0", rob_tail_out); end
    total++; if ({commit_reg_en_out, commit_store_en_out, flush_out} !== 3'b000) begin bad++; $display("[TB] FAIL reset_pulses got=%03b exp=000", {commit_reg_en_out, commit_store_en_out, flush_out}); end
    total++; if (commit_value_out !== 32'd0 || flush_pc_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_data got=%h/%h exp=0/0", commit_value_out, flush_pc_out); end
    rst_n_in = 1;
  endtask

  task automatic test_alloc_commit();
    for (int i = 1; i <= 3; i++) begin
      alloc(5'(i), 0, 0);
      step();
    end
    idle();
    total++; if (rob_tail_out !== 4'd3) begin bad++; $display("[TB] FAIL alloc_tail got=%0d exp=3", rob_tail_out); end
    total++; if (rob_head_out !== 4'd0) begin bad++; $display("[TB] FAIL alloc_head got=%0d exp=0", rob_head_out); end
    total++; if (rob_empty_out !== 1'b0) begin bad++; $display("[TB] FAIL alloc_empty got=%0b exp=0", rob_empty_out); end
    cdb(4'd0, 32'h55, 0, 32'h0);
    step();
    idle();
    total++; if (commit_reg_en_out !== 1'b0) begin bad++; $display("[TB] FAIL commit_early got=%0b exp=0", commit_reg_en_out); end
    step();
    total++; if (commit_reg_en_out !== 1'b1) begin bad++; $display("[TB] FAIL commit_en got=%0b exp=1", commit_reg_en_out); end
    total++; if (commit_rd_out !== 5'd1) begin bad++; $display("[TB] FAIL commit_rd got=%0d exp=1", commit_rd_out); end
    total++; if (commit_value_out !== 32'h55) begin bad++; $display("[TB] FAIL commit_value got=%h exp=00000055", commit_value_out); end
    total++; if (commit_idx_out !== 4'd0) begin bad++; $display("[TB] FAIL commit_idx got=%0d exp=0", commit_idx_out); end
    total++; if (rob_head_out !== 4'd1) begin bad++; $display("[TB] FAIL commit_head got=%0d exp=1", rob_head_out); end
    step();
    total++; if (commit_reg_en_out !== 1'b0) begin bad++; $display("[TB] FAIL commit_pulse_width got=%0b exp=0", commit_reg_en_out); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(5'd5, 0, 0);
      step();
    end
    total++; if (rob_tail_out !== 4'd0 || rob_head_out !== 4'd0) begin bad++; $display("[TB] FAIL full_ptrs got=%0d/%0d exp=0/0", rob_head_out, rob_tail_out); end
    total++; if (rob_empty_out !== 1'b0) begin bad++; $display("[TB] FAIL full_empty got=%0b exp=0", rob_empty_out); end
    step();
    total++; if (rob_tail_out !== 4'd0) begin bad++; $display("[TB] FAIL full_overflow_tail got=%0d exp=0", rob_tail_out); end
    idle();
    cdb(4'd0, 32'hA0, 0, 32'h0);
    step();
    idle();
    alloc(5'd7, 0, 0);
    step();
    total++; if (rob_head_out !== 4'd1 || rob_tail_out !== 4'd1) begin bad++; $display("[TB] FAIL full_swap_ptrs got=%0d/%0d exp=1/1", rob_head_out, rob_tail_out); end
    total++; if (commit_reg_en_out !== 1'b1 || commit_value_out !== 32'hA0 || commit_idx_out !== 4'd0) begin bad++; $display("[TB] FAIL full_swap_commit got=%0b/%h/%0d exp=1/000000a0/0", commit_reg_en_out, commit_value_out, commit_idx_out); end
    step();
    total++; if (rob_tail_out !== 4'd1) begin bad++; $display("[TB] FAIL full_kept_tail got=%0d exp=1", rob_tail_out); end
    total++; if (rob_empty_out !== 1'b0) begin bad++; $display("[TB] FAIL full_kept_empty got=%0b exp=0", rob_empty_out); end
    idle();
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(5'd1, 0, 0); step();
    alloc(5'd2, 0, 0); step();
    alloc(5'd3, 0, 1); step();
    idle();
    cdb(4'd2, 32'h22, 1, 32'h1000); step();
    cdb(4'd0, 32'h10, 0, 32'h0);    step();
    cdb(4'd1, 32'h11, 0, 32'h0);    step();
    total++; if (commit_reg_en_out !== 1'b1 || commit_rd_out !== 5'd1 || commit_value_out !== 32'h10) begin bad++; $display("[TB] FAIL mp_commit0 got=%0b/%0d/%h exp=1/1/00000010", commit_reg_en_out, commit_rd_out, commit_value_out); end
    idle();
    step();
    total++; if (commit_rd_out !== 5'd2 || commit_value_out !== 32'h11 || flush_out !== 1'b0) begin bad++; $display("[TB] FAIL mp_commit1 got=%0d/%h/%0b exp=2/00000011/0", commit_rd_out, commit_value_out, flush_out); end
    alloc(5'd9, 0, 0);
    cdb(4'd3, 32'h99, 0, 32'h0);
    step();
    idle();
    total++; if (flush_out !== 1'b1 || flush_pc_out !== 32'h1000) begin bad++; $display("[TB] FAIL mp_flush got=%0b/%h exp=1/00001000", flush_out, flush_pc_out); end
    total++; if (commit_reg_en_out !== 1'b1 || commit_rd_out !== 5'd3 || commit_value_out !== 32'h22 || commit_idx_out !== 4'd2) begin bad++; $display("[TB] FAIL mp_branch_commit got=%0b/%0d/%h/%0d exp=1/3/00000022/2", commit_reg_en_out, commit_rd_out, commit_value_out, commit_idx_out); end
    total++; if (rob_head_out !== 4'd0 || rob_tail_out !== 4'd0 || rob_empty_out !== 1'b1) begin bad++; $display("[TB] FAIL mp_cleared got=%0d/%0d/%0b exp=0/0/1", rob_head_out, rob_tail_out, rob_empty_out); end
    step();
    total++; if (flush_out !== 1'b0 || rob_empty_out !== 1'b1) begin bad++; $display("[TB] FAIL mp_after got=%0b/%0b exp=0/1", flush_out, rob_empty_out); end
  endtask

  task automatic test_store();
    alloc(5'd0, 1, 0);
    step();
    idle();
    total++; if (commit_store_en_out !== 1'b0 || rob_empty_out !== 1'b0) begin bad++; $display("[TB] FAIL st_alloc got=%0b/%0b exp=0/0", commit_store_en_out, rob_empty_out); end
    step();
    total++; if (commit_store_en_out !== 1'b1 || commit_reg_en_out !== 1'b0 || commit_idx_out !== 4'd0) begin bad++; $display("[TB] FAIL st_commit got=%0b/%0b/%0d exp=1/0/0", commit_store_en_out, commit_reg_en_out, commit_idx_out); end
    total++; if (rob_head_out !== 4'd1 || rob_empty_out !== 1'b1) begin bad++; $display("[TB] FAIL st_head got=%0d/%0b exp=1/1", rob_head_out, rob_empty_out); end
    step();
    total++; if (commit_store_en_out !== 1'b0) begin bad++; $display("[TB] FAIL st_pulse_width got=%0b exp=0", commit_store_en_out); end
  endtask

  task automatic test_stall();
    alloc(5'd4, 1, 0);
    step();
    rdy_in = 0;
    alloc(5'd6, 0, 0);
    step();
    total++; if (commit_store_en_out !== 1'b0 || rob_head_out !== 4'd1) begin bad++; $display("[TB] FAIL stall_frozen got=%0b/%0d exp=0/1", commit_store_en_out, rob_head_out); end
    total++; if (rob_tail_out !== 4'd2) begin bad++; $display("[TB] FAIL stall_tail got=%0d exp=2", rob_tail_out); end
    rdy_in = 1;
    idle();
    step();
    total++; if (commit_store_en_out !== 1'b1 || commit_idx_out !== 4'd1 || rob_head_out !== 4'd2) begin bad++; $display("[TB] FAIL stall_resume got=%0b/%0d/%0d exp=1/1/2", commit_store_en_out, commit_idx_out, rob_head_out); end
  endtask

  initial begin
    test_reset();
    test_alloc_commit();
    test_full();
    test_mispredict();
    test_store();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
